// File: rtl/pipelined_carry_select_adder_if.sv
// Valid/ready operand and result channels of the pipelined carry-select adder.
// The master drives operands and out_ready; the slave (the adder) drives the rest.
interface pipelined_carry_select_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, approx_en, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, approx_en, out_ready,
    output in_ready, out_valid, S, Cout, Ovf
  );
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Two-stage carry-select adder with an optional OR-approximated low part.
// Stage 1 precomputes every block for carry-in 0 and 1; stage 2 ripples the block selects.
module pipelined_carry_select_adder #(
  parameter int WIDTH       = 16,
  parameter int BLOCK       = 4,
  parameter int APPROX_BITS = 4
) (
  input logic                          clk,
  input logic                          rst,
  pipelined_carry_select_adder_if.slave bus
);

  localparam int NBLK    = WIDTH / BLOCK;
  localparam int NAPX    = APPROX_BITS / BLOCK;
  localparam int APX_W   = (APPROX_BITS > 0) ? APPROX_BITS : 1;
  localparam bit HAS_APX = (APPROX_BITS > 0);

  logic                             v1_q;
  logic                             v2_q;
  logic                             load1;
  logic                             load2;

  logic [NBLK-1:0][BLOCK-1:0]       sum0_d, sum0_q;
  logic [NBLK-1:0][BLOCK-1:0]       sum1_d, sum1_q;
  logic [NBLK-1:0]                  cy0_d, cy0_q;
  logic [NBLK-1:0]                  cy1_d, cy1_q;
  logic [APX_W-1:0]                 orLow_d, orLow_q;
  logic                             cinSel_d, cinSel_q;
  logic                             approx_d, approx_q;
  logic                             aMsb_d, aMsb_q;
  logic                             bMsb_d, bMsb_q;

  logic [WIDTH-1:0]                 s_d, s_q;
  logic                             cout_d, cout_q;
  logic                             ovf_d, ovf_q;
  logic                             selCarry;

  assign load2        = !v2_q || bus.out_ready;
  assign load1        = !v1_q || load2;
  assign bus.in_ready = load1;
  assign bus.out_valid = v2_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;

  // In approx mode the first exact block is fed by the AND of the top approximated bits
  always_comb begin
    for (int i = 0; i < NBLK; i++) begin
      {cy0_d[i], sum0_d[i]} = {1'b0, bus.A[i*BLOCK +: BLOCK]} + {1'b0, bus.B[i*BLOCK +: BLOCK]};
      {cy1_d[i], sum1_d[i]} = {1'b0, bus.A[i*BLOCK +: BLOCK]} + {1'b0, bus.B[i*BLOCK +: BLOCK]}
                              + {{BLOCK{1'b0}}, 1'b1};
    end
    approx_d = bus.approx_en && HAS_APX;
    orLow_d  = bus.A[APX_W-1:0] | bus.B[APX_W-1:0];
    cinSel_d = approx_d ? (bus.A[APX_W-1] & bus.B[APX_W-1]) : bus.Cin;
    aMsb_d   = bus.A[WIDTH-1];
    bMsb_d   = bus.B[WIDTH-1];
  end

  // Approximated blocks pass the carry through untouched so it lands on block NAPX
  always_comb begin
    s_d      = '0;
    selCarry = cinSel_q;
    for (int i = 0; i < NBLK; i++) begin
      if (!(approx_q && (i < NAPX))) begin
        s_d[i*BLOCK +: BLOCK] = selCarry ? sum1_q[i] : sum0_q[i];
        selCarry              = selCarry ? cy1_q[i] : cy0_q[i];
      end
    end
    if (approx_q) begin
      s_d[APX_W-1:0] = orLow_q;
    end
    cout_d = selCarry;
    ovf_d  = (aMsb_q == bMsb_q) && (s_d[WIDTH-1] != aMsb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sum0_q   <= '0;
      sum1_q   <= '0;
      cy0_q    <= '0;
      cy1_q    <= '0;
      orLow_q  <= '0;
      cinSel_q <= 1'b0;
      approx_q <= 1'b0;
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (load1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          sum0_q   <= sum0_d;
          sum1_q   <= sum1_d;
          cy0_q    <= cy0_d;
          cy1_q    <= cy1_d;
          orLow_q  <= orLow_d;
          cinSel_q <= cinSel_d;
          approx_q <= approx_d;
          aMsb_q   <= aMsb_d;
          bMsb_q   <= bMsb_d;
        end
      end
      // Result registers only move when a real transaction arrives, so a stalled output never changes
      if (load2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s_q    <= s_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder (WIDTH=16, BLOCK=4, APPROX_BITS=4).
// A scoreboard of reference results follows every transfer; directed cases add exact-value checks.
module tb_pipelined_carry_select_adder;

  logic clk;
  logic rst;
  int   vecCount;
  int   missCount;
  int   inCount;
  int   outCount;
  logic [17:0] expQ[$];
  logic        prevStall;
  logic [17:0] prevOut;

  pipelined_carry_select_adder_if #(.WIDTH(16)) bus();

  pipelined_carry_select_adder #(
    .WIDTH(16),
    .BLOCK(4),
    .APPROX_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] refAdd(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic apx);
    logic [16:0] full;
    logic [12:0] hi;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    if (!apx) begin
      full = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      s    = full[15:0];
      cout = full[16];
    end else begin
      hi   = {1'b0, a[15:4]} + {1'b0, b[15:4]} + {12'b0, a[3] & b[3]};
      s    = {hi[11:0], a[3:0] | b[3:0]};
      cout = hi[12];
    end
    ovf = (a[15] == b[15]) && (s[15] != a[15]);
    return {ovf, cout, s};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard and hold checker, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
        checkOutput("holdData", 32'({bus.Ovf, bus.Cout, bus.S}), 32'(prevOut));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) checkOutput("unexpectedOut", 32'd1, 32'd0);
        else checkOutput("stream", 32'({bus.Ovf, bus.Cout, bus.S}), 32'(expQ.pop_front()));
        outCount++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(refAdd(bus.A, bus.B, bus.Cin, bus.approx_en));
        inCount++;
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevOut   = {bus.Ovf, bus.Cout, bus.S};
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic apx);
    int n;
    bus.A         = a;
    bus.B         = b;
    bus.Cin       = cin;
    bus.approx_en = apx;
    bus.in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput("acceptTimeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic runDirected(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic apx,
                             input logic [15:0] expS, input logic expCout, input logic expOvf);
    applyStimulus(a, b, cin, apx);
    @(negedge clk);
    checkOutput({tag, "_notYet"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_S"}, 32'(bus.S), 32'(expS));
    checkOutput({tag, "_Cout"}, 32'(bus.Cout), 32'(expCout));
    checkOutput({tag, "_Ovf"}, 32'(bus.Ovf), 32'(expOvf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    clk           = 1'b0;
    rst           = 1'b1;
    vecCount      = 0;
    missCount     = 0;
    inCount       = 0;
    outCount      = 0;
    prevStall     = 1'b0;
    prevOut       = '0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.approx_en = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstS", 32'(bus.S), 32'd0);
    checkOutput("rstCout", 32'(bus.Cout), 32'd0);
    checkOutput("rstOvf", 32'(bus.Ovf), 32'd0);
    checkOutput("rstReady", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    runDirected("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    runDirected("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    runDirected("approx", 16'h000F, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b0, 1'b0);
    runDirected("exact", 16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);

    // Backpressure: two accepted, the third waits while the output is held
    base = outCount;
    bus.out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b0);
    bus.A         = 16'h00F3;
    bus.B         = 16'h0018;
    bus.Cin       = 1'b1;
    bus.approx_en = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bpReady", 32'(bus.in_ready), 32'd0);
      checkOutput("bpS", 32'(bus.S), 32'h2345);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpReadyBack", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bpDrained", 32'(expQ.size()), 32'd0);
    checkOutput("bpCount", 32'(outCount - base), 32'd3);

    // Reset with two transactions in flight
    applyStimulus(16'h0101, 16'h0202, 1'b0, 1'b0);
    applyStimulus(16'h0303, 16'h0404, 1'b0, 1'b1);
    base = outCount;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstS", 32'(bus.S), 32'd0);
    checkOutput("midRstReady", 32'(bus.in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midRstNoEmit", 32'(outCount - base), 32'd0);

    // Random streaming with random backpressure
    base = inCount;
    for (int cyc = 0; (inCount - base) < 10000 && cyc < 60000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.A         = 16'($urandom);
      bus.B         = 16'($urandom);
      bus.Cin       = 1'($urandom);
      bus.approx_en = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("streamAccepted", 32'(inCount - base), 32'd10000);
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("streamDrained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
